uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 234, meaning clock cycles per bit (27 MHz / 115200 baud).
REQ-002 SHALL derive HALF_DELAY_WAIT = DELAY_FRAMES/2 (integer division) as a localparam.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port uart_rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready, input, 1 bit: consumer accepts the byte when rx_valid && rx_ready.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, set when a byte is lost.

Function
REQ-011 SHALL pass uart_rx through a 2-flop synchronizer; all logic uses the synchronized rx_s only.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK, with a counter of at least 16 bits and a 3-bit bit index.
REQ-013 In IDLE: SHALL go to START when rx_s==0, clearing the counter; SHALL otherwise stay in IDLE.
REQ-014 In START: SHALL increment the counter until counter+1==HALF_DELAY_WAIT. At that point it SHALL go to DATA (counter=0, bit index=0) if rx_s==0, or to IDLE if rx_s==1, treating the edge as a glitch with no output.
REQ-015 In DATA: when counter+1==DELAY_FRAMES, SHALL shift rx_s into shift_reg[bit index] and clear the counter. After bit index 7 it SHALL go to STOP; otherwise it SHALL increment the bit index.
REQ-016 In STOP: when counter+1==DELAY_FRAMES with rx_s==1, SHALL deliver the byte (REQ-018) and go to IDLE.
REQ-017 In STOP: when counter+1==DELAY_FRAMES with rx_s==0, SHALL pulse frame_err for exactly 1 cycle, discard the byte, and go to BREAK. BREAK SHALL stay until rx_s==1, then go to IDLE.
REQ-018 Delivery: if rx_valid==0, or rx_valid && rx_ready in the same cycle, SHALL load rx_data and hold rx_valid=1. Otherwise SHALL keep the old rx_data and rx_valid, drop the new byte, and set overrun=1.
REQ-019 rx_valid SHALL clear the cycle after rx_valid && rx_ready unless a delivery occurs in that same cycle. rx_data SHALL stay stable while rx_valid==1 and no delivery occurs.
REQ-020 overrun SHALL clear on the next rx_valid && rx_ready handshake, unless a new overrun occurs in that same cycle, in which case set wins.
REQ-021 Latency from the uart_rx falling edge to rx_valid=1 SHALL be 3 + HALF_DELAY_WAIT + 9*DELAY_FRAMES cycles, ±1.
REQ-022 SHALL receive back-to-back frames with zero idle bits between stop bit and next start bit.

Reset
REQ-023 On rst=1, SHALL immediately force: state=IDLE, counter=0, bit index=0, shift_reg=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no output. After release, SHALL wait in IDLE for the next falling edge of rx_s.

Structure
REQ-025 Shared package uart_pkg SHALL hold the state encodings (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4) and the DELAY_FRAMES default 234. The existing transmitter SHALL use the same constant.
REQ-026 The synchronizer SHALL be a sub-module sync_2ff (clk, rst, d, q; reset value 1). All else is in uart_receiver.

Verification (bench DELAY_FRAMES=16)
REQ-027 Single byte 0x4C ('L'), rx_ready=1 -> rx_data=0x4C with rx_valid high 1 cycle, at 155±1 cycles after the falling edge, frame_err=0.
REQ-028 Back-to-back bytes "Lushay" with no idle gap, rx_ready=1 -> six deliveries in order 0x4C,0x75,0x73,0x68,0x61,0x79, overrun=0.
REQ-029 Bytes 0x55 then 0xAA with rx_ready=0 -> rx_data stays 0x55, overrun=1. Then pulse rx_ready for 1 cycle -> rx_valid=0 and overrun=0.
REQ-030 Frame 0x41 with stop bit forced low, then line high -> one frame_err pulse, no rx_valid. A following 0x42 is received correctly.
REQ-031 Low glitch of 4 cycles on idle line -> returns to IDLE, no rx_valid, no frame_err.
REQ-032 rst pulse during bit 4 of 0xFF, then a clean 0x3C -> no output for the aborted frame, then rx_data=0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: bit timing default and receiver FSM encodings.
// Imported by the receiver and by the transmitter.
package uart_pkg;

  localparam int DELAY_FRAMES_DEFAULT = 234;
  localparam int CNT_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_DATA  = 3'd2;
  localparam state_t S_STOP  = 3'd3;
  localparam state_t S_BREAK = 3'd4;

  function automatic logic [CNT_W-1:0] cnt_const(
    input int v
  );
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-stream output bundle of the UART receiver.
// Valid/ready handshake plus error flags.
interface uart_receiver_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level.
// Resets to 1 so an idle serial line reads idle.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling.
// Delivers bytes over a valid/ready bundle.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  uart_receiver_if.master rx
);

  localparam int HALF_DELAY_WAIT = DELAY_FRAMES / 2;

  localparam logic [CNT_W-1:0] FULL_C =
    cnt_const(DELAY_FRAMES);
  localparam logic [CNT_W-1:0] HALF_C =
    cnt_const(HALF_DELAY_WAIT);

  logic             rx_s;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic [7:0]       shreg_q;
  logic [7:0]       shreg_d;
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic             valid_q;
  logic             valid_d;
  logic             ferr_q;
  logic             ferr_d;
  logic             ovr_q;
  logic             ovr_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             half_hit;
  logic             full_hit;
  logic             deliver;
  logic             hs;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rx_s)
  );

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign half_hit = (cnt_inc == HALF_C);
  assign full_hit = (cnt_inc == FULL_C);
  assign hs       = valid_q & rx.rx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      (state_q == S_START): begin
        if (half_hit) begin
          cnt_d = '0;
          if (rx_s) begin
            // Line went back high: treat as glitch.
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      (state_q == S_DATA): begin
        if (full_hit) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      (state_q == S_STOP): begin
        if (full_hit) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      (state_q == S_BREAK): begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new byte lands only if the holding slot is free or
  // is being consumed this very cycle; otherwise it is lost.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || hs) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver.
// Serial frames are built bit by bit; expectations come from sent bytes.
module tb_uart_receiver;

  localparam int DF = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  uart_receiver_if bus ();

  uart_receiver #(
    .DELAY_FRAMES (DF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .rx      (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  got[$];
  int          fe_cnt = 0;
  int          fe_run = 0;
  int          fe_maxrun = 0;
  int          rise_cnt = 0;
  int unsigned rise_cyc = 0;
  int          vrun = 0;
  int          last_vlen = 0;
  logic        pv = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
    if (bus.rx_valid && !pv) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (bus.rx_valid) begin
      vrun <= vrun + 1;
    end else begin
      vrun <= 0;
      if (pv) last_vlen <= vrun;
    end
    pv <= bus.rx_valid;
    if (bus.frame_err) begin
      fe_run <= fe_run + 1;
      if (fe_run + 1 > fe_maxrun) fe_maxrun <= fe_run + 1;
      if (fe_run == 0) fe_cnt <= fe_cnt + 1;
    end else begin
      fe_run <= 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    uart_rx = 1'b0;
    tick(DF);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DF);
    end
    uart_rx = stopb;
    tick(DF);
    uart_rx = 1'b1;
  endtask

  initial begin
    int base;
    int rb;
    int feb;
    int lat;
    int unsigned c0;
    int k;
    logic [7:0] lush [6];
    logic [7:0] expq[$];
    logic [7:0] b;

    lush[0] = 8'h4C; lush[1] = 8'h75; lush[2] = 8'h73;
    lush[3] = 8'h68; lush[4] = 8'h61; lush[5] = 8'h79;

    bus.rx_ready = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_ovr", bus.overrun, 1'b0);
    rst = 1'b0;
    tick(2);

    // single byte, latency and one-cycle valid
    bus.rx_ready = 1'b1;
    base = got.size();
    rb = rise_cnt;
    feb = fe_cnt;
    c0 = cyc;
    send(8'h4C, 1'b1);
    tick(DF);
    lat = int'(rise_cyc - c0);
    chk("latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
    chk("L_rises", rise_cnt - rb, 1);
    chk("L_count", got.size() - base, 1);
    if (got.size() > base) chk("L_data", got[base], 8'h4C);
    chk("L_vlen", last_vlen, 1);
    chk("L_ferr", fe_cnt - feb, 0);
    chk("L_hold", bus.rx_data, 8'h4C);

    // back-to-back string
    base = got.size();
    for (int i = 0; i < 6; i++) send(lush[i], 1'b1);
    tick(2 * DF);
    chk("lush_count", got.size() - base, 6);
    for (int i = 0; i < 6; i++)
      if (got.size() > base + i)
        chk($sformatf("lush_%0d", i), got[base + i], lush[i]);
    chk("lush_ovr", bus.overrun, 1'b0);

    // overrun with consumer stalled
    bus.rx_ready = 1'b0;
    base = got.size();
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    tick(DF);
    chk("ovr_data", bus.rx_data, 8'h55);
    chk("ovr_valid", bus.rx_valid, 1'b1);
    chk("ovr_flag", bus.overrun, 1'b1);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    chk("ovr_clr_valid", bus.rx_valid, 1'b0);
    chk("ovr_clr_flag", bus.overrun, 1'b0);
    chk("ovr_count", got.size() - base, 1);
    if (got.size() > base) chk("ovr_got", got[base], 8'h55);

    // framing error then recovery
    bus.rx_ready = 1'b1;
    feb = fe_cnt;
    rb = rise_cnt;
    send(8'h41, 1'b0);
    tick(2 * DF);
    chk("fe_pulses", fe_cnt - feb, 1);
    chk("fe_novalid", rise_cnt - rb, 0);
    base = got.size();
    send(8'h42, 1'b1);
    tick(DF);
    chk("fe_next_cnt", got.size() - base, 1);
    if (got.size() > base) chk("fe_next", got[base], 8'h42);

    // short glitch on idle line
    feb = fe_cnt;
    rb = rise_cnt;
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(3 * DF);
    chk("gl_valid", rise_cnt - rb, 0);
    chk("gl_ferr", fe_cnt - feb, 0);

    // reset mid-frame
    rb = rise_cnt;
    uart_rx = 1'b0;
    tick(DF);
    uart_rx = 1'b1;
    tick(4 * DF + DF / 2);
    rst = 1'b1;
    tick(2);
    chk("mr_data", bus.rx_data, 8'h00);
    chk("mr_valid", bus.rx_valid, 1'b0);
    rst = 1'b0;
    tick(5 * DF);
    chk("mr_nout", rise_cnt - rb, 0);
    base = got.size();
    send(8'h3C, 1'b1);
    tick(DF);
    chk("mr_cnt", got.size() - base, 1);
    if (got.size() > base) chk("mr_got", got[base], 8'h3C);
    chk("mr_data2", bus.rx_data, 8'h3C);

    // random bytes with random idle gaps
    base = got.size();
    expq.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      expq.push_back(b);
      send(b, 1'b1);
      tick($urandom_range(0, 2 * DF));
    end
    tick(2 * DF);
    chk("rnd_count", got.size() - base, expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (got.size() > base + i)
        chk($sformatf("rnd_%0d", i), got[base + i], expq[i]);

    // random bursts into a stalled consumer
    for (int t = 0; t < 4; t++) begin
      bus.rx_ready = 1'b0;
      k = $urandom_range(1, 3);
      expq.delete();
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        expq.push_back(b);
        send(b, 1'b1);
      end
      tick(DF);
      chk($sformatf("burst%0d_data", t), bus.rx_data, expq[0]);
      chk($sformatf("burst%0d_valid", t), bus.rx_valid, 1'b1);
      chk($sformatf("burst%0d_ovr", t), bus.overrun, k > 1);
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
      chk($sformatf("burst%0d_clr", t), bus.rx_valid, 1'b0);
      chk($sformatf("burst%0d_oclr", t), bus.overrun, 1'b0);
    end

    chk("fe_width", fe_maxrun, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
